// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the pipeline data-memory port.
// Byte-addressed 32-bit memory with a valid/ready request, a fixed
// LATENCY-cycle access, a one-cycle resp_valid pulse and a busy flag
// the pipeline uses to stall its MEM stage.
//
// Handshake: a request is accepted on a rising clock edge where
// req_valid=1, req_ready=1 (state IDLE) and memread|memwrite=1. All
// request fields are captured at that edge. resp_valid pulses exactly
// LATENCY edges later. No other request is accepted until the responder
// is back in IDLE.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   -> misaligned lh/lhu/sh/lw/sw respond with error=1, no access
//   undefined -> low address bits are forced to natural alignment
//
// DEPTH_WORDS must be a power of two (>= 2); the word index is the
// address word field truncated to log2(DEPTH_WORDS) bits, so accesses
// wrap silently. o_dbg_state exposes the FSM state for observation.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  fun3,
   input  logic [31:0] address,
   input  logic [31:0] writedata,
   output logic        resp_valid,
   output logic [31:0] readdata,
   output logic        error,
   output logic        busy,
   output logic [1:0]  o_dbg_state
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int AW    = IDX_W + 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]       r_state;
   logic [3:0]       r_cnt;
   logic             r_rd;
   logic             r_wr;
   logic [2:0]       r_f3;
   logic [AW-1:0]    r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_readdata;
   logic             r_error;
   logic [31:0]      r_mem [DEPTH_WORDS];

   logic             w_accept;
   logic             w_do_access;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_word;
   logic [1:0]       w_size;
   logic [1:0]       w_lane;
   logic             w_illegal;
   logic             w_misalign;
   logic             w_error;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;
   logic [31:0]      w_merged;
   logic             w_unused_addr;

   // Address bits above the word index only select an alias of the array.
   assign w_unused_addr = &{1'b0, address[31:AW]};

   assign w_accept    = req_valid & (memread | memwrite) & (r_state == ST_IDLE);
   assign w_do_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
   assign w_idx       = r_addr[AW-1:2];
   assign w_word      = r_mem[w_idx];
   assign w_size      = r_f3[1:0];

   assign w_illegal = (r_f3 == 3'b011) | (r_f3 == 3'b110) | (r_f3 == 3'b111)
                    | (r_rd & r_wr);

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_misalign = ((w_size == 2'b01) & r_addr[0])
                     | ((w_size == 2'b10) & (r_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_error = w_illegal | w_misalign;

   // Byte offset inside the word, forced to natural alignment for the access size.
   always_comb begin
      w_lane = r_addr[1:0];
      case (w_size)
         2'b01:   w_lane = {r_addr[1], 1'b0};
         2'b10:   w_lane = 2'b00;
         default: w_lane = r_addr[1:0];
      endcase
   end

   assign w_byte = w_word[{w_lane, 3'b000} +: 8];
   assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

   // Load result: sign-extend unless fun3[2] selects the unsigned variant.
   always_comb begin
      w_load = w_word;
      case (w_size)
         2'b00:   w_load = {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
         2'b01:   w_load = {{16{w_half[15] & ~r_f3[2]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   // Store merge: replace only the addressed lanes of the current word.
   always_comb begin
      w_merged = w_word;
      case (w_size)
         2'b00:   w_merged[{w_lane, 3'b000} +: 8]  = r_wdata[7:0];
         2'b01:   w_merged[{w_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merged = r_wdata;
      endcase
   end

   // Memory array write; never reset, and state is IDLE under reset so no write can slip through.
   always_ff @(posedge clock) begin
      if (w_do_access && r_wr && !w_error) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   // Request capture, latency countdown and response registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_f3       <= 3'b000;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_readdata <= 32'd0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rd    <= memread;
                  r_wr    <= memwrite;
                  r_f3    <= fun3;
                  r_addr  <= address[AW-1:0];
                  r_wdata <= writedata;
                  r_cnt   <= CNT_INIT;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_readdata <= (r_rd && !w_error) ? w_load : 32'd0;
                  r_error    <= w_error;
                  r_state    <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign resp_valid  = (r_state == ST_RESP);
   assign readdata    = r_readdata;
   assign error       = r_error;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model, per-cycle
// compare process, directed literal cases and randomized traffic.
module tb_data_mem_responder;

   localparam int L  = 2;
   localparam int DW = 256;
   localparam int NB = DW * 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic [2:0]  fun3 = 3'b000;
   logic [31:0] address = 32'd0;
   logic [31:0] writedata = 32'd0;
   logic        resp_valid;
   logic [31:0] readdata;
   logic        error;
   logic        busy;
   logic [1:0]  o_dbg_state;

   data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(L)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .memread     (memread),
      .memwrite    (memwrite),
      .fun3        (fun3),
      .address     (address),
      .writedata   (writedata),
      .resp_valid  (resp_valid),
      .readdata    (readdata),
      .error       (error),
      .busy        (busy),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [7:0]  m_mem [NB];
   int          pend_acc = -1;
   logic        p_rd, p_wr;
   logic [2:0]  p_f3;
   logic [31:0] p_addr, p_wd;
   logic [31:0] last_rd = 32'd0;
   logic [31:0] exp_q [$];

   int          last_acc = 0;
   int          dut_rsp_cyc = -1;
   logic [31:0] dut_rsp_rd = 32'd0;
   logic        dut_rsp_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference: memory as a flat little-endian byte array.
   task automatic model_access(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] rdv, output logic err);
      int unsigned a;
      int n;
      logic [63:0] v;
      logic [31:0] t;
      a   = addr % NB;
      n   = 1 << f3[1:0];
      v   = 64'd0;
      rdv = 32'd0;
      err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (rd && wr);
      if (err) return;
`ifdef DMEM_MISALIGN_CHECK_EN
      if ((a % n) != 0) begin
         err = 1'b1;
         return;
      end
`endif
      a = a - (a % n);
      if (wr) begin
         for (int i = 0; i < n; i++) begin
            t = wd >> (8 * i);
            m_mem[a + i] = t[7:0];
         end
      end else begin
         for (int i = 0; i < n; i++) v = v | (64'(m_mem[a + i]) << (8 * i));
         if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
         rdv = v[31:0];
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clock) begin
      logic        exp_busy, exp_rv, m_err;
      logic [31:0] m_rd;
      if (resp_valid) begin
         dut_rsp_rd  = readdata;
         dut_rsp_err = error;
         dut_rsp_cyc = cyc;
      end
      if (reset) begin
         check("busy_in_reset", {31'd0, busy}, 32'd0);
         check("resp_valid_in_reset", {31'd0, resp_valid}, 32'd0);
         check("readdata_in_reset", readdata, 32'd0);
      end else begin
         exp_busy = (pend_acc >= 0);
         exp_rv   = exp_busy && (cyc == pend_acc + L);
         check("busy", {31'd0, busy}, {31'd0, exp_busy});
         check("req_ready", {31'd0, req_ready}, {31'd0, !exp_busy});
         check("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
         if (exp_rv) begin
            model_access(p_rd, p_wr, p_f3, p_addr, p_wd, m_rd, m_err);
            exp_q.push_back(m_rd);
            last_rd = exp_q.pop_front();
            check("readdata", readdata, last_rd);
            check("error", {31'd0, error}, {31'd0, m_err});
            pend_acc = -1;
         end else begin
            check("readdata_hold", readdata, last_rd);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n = 0;
      while (pend_acc >= 0 && n < 100) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (pend_acc >= 0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout at cycle %0d: got busy expected idle", cyc);
         pend_acc = -1;
      end
   endtask

   task automatic junk_inputs();
      memread   = 1'($urandom_range(0, 1));
      memwrite  = 1'($urandom_range(0, 1));
      fun3      = 3'($urandom_range(0, 7));
      address   = $urandom;
      writedata = $urandom;
   endtask

   // One request; while it is in flight, req_valid stays high with junk fields.
   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      wait_idle();
      @(negedge clock);
      #1;
      req_valid = 1'b1; memread = rd; memwrite = wr;
      fun3 = f3; address = addr; writedata = wd;
      @(posedge clock);
      #1;
      if (rd || wr) begin
         pend_acc = cyc; last_acc = cyc;
         p_rd = rd; p_wr = wr; p_f3 = f3; p_addr = addr; p_wd = wd;
         junk_inputs();
         wait_idle();
      end
      req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
   endtask

   task automatic issue_chk(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            input logic exp_err);
      dut_rsp_cyc = -1;
      issue(rd, wr, f3, addr, wd);
      @(negedge clock);
      #1;
      check({name, "_latency"}, 32'(dut_rsp_cyc - last_acc), 32'(L));
      check({name, "_data"}, dut_rsp_rd, exp_rd);
      check({name, "_err"}, {31'd0, dut_rsp_err}, {31'd0, exp_err});
   endtask

   // Accept a request, then assert reset while it is still counting down.
   task automatic reset_mid(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int k;
      wait_idle();
      @(negedge clock);
      #1;
      req_valid = 1'b1; memread = 1'b0; memwrite = 1'b1;
      fun3 = f3; address = addr; writedata = wd;
      @(posedge clock);
      #1;
      pend_acc = cyc;
      p_rd = 1'b0; p_wr = 1'b1; p_f3 = f3; p_addr = addr; p_wd = wd;
      junk_inputs();
      k = $urandom_range(1, L);
      repeat (k) @(negedge clock);
      #2;
      reset = 1'b1;
      pend_acc = -1;
      last_rd = 32'd0;
      #1;
      check("busy_async_drop", {31'd0, busy}, 32'd0);
      check("resp_valid_async_drop", {31'd0, resp_valid}, 32'd0);
      @(negedge clock);
      #2;
      req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
      #1;
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_state", {30'd0, o_dbg_state}, 32'd0);

      issue_chk("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      issue_chk("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      issue_chk("sb11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h7F, 32'h0, 1'b0);
      issue_chk("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
      issue_chk("lb13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      issue_chk("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      issue_chk("sh22", 1'b0, 1'b1, 3'b001, 32'h22, 32'h8001, 32'h0, 1'b0);
      issue_chk("lh22", 1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
      issue_chk("lhu22", 1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
      issue_chk("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0);
      issue_chk("f3_011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      issue_chk("rd_wr", 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1);
      issue_chk("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
      issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
      reset_mid(3'b010, 32'h40, 32'h12345678);
      issue_chk("lw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);
      issue_chk("sw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
      issue_chk("lw42", 1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1);
`else
      issue_chk("lw42", 1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 32'hCAFEF00D, 1'b0);
`endif
      issue_chk("sw_wrap", 1'b0, 1'b1, 3'b010, 32'h450, 32'h11223344, 32'h0, 1'b0);
      issue_chk("lw_wrap", 1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'h11223344, 1'b0);

      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         a = (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 127));
         if (r < 8) begin
            issue(1'b0, 1'b0, 3'($urandom_range(0, 7)), a, $urandom);
         end else if (r < 14) begin
            reset_mid(3'($urandom_range(0, 2)), a, $urandom);
         end else if (r < 20) begin
            f3 = 3'($urandom_range(0, 2)) == 3'd0 ? 3'd3 : 3'($urandom_range(6, 7));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b0, f3, a, $urandom);
         end else if (r < 26) begin
            issue(1'b1, 1'b1, 3'($urandom_range(0, 2)), a, $urandom);
         end else if (r < 62) begin
            issue(1'b0, 1'b1, 3'($urandom_range(0, 2)), a, $urandom);
         end else begin
            r = $urandom_range(0, 4);
            f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            issue(1'b1, 1'b0, f3, a, 32'h0);
         end
      end
      wait_idle();
      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
